// File: rtl/line_pkg.sv
// Shared widths, the coordinate-width helper and the registered setup-result record
// used by the line setup pipeline.
package line_pkg;
  localparam int X_W_DEF   = 10;
  localparam int Y_W_DEF   = 9;
  // Widest coordinate the result record can carry; instances slice it down to C_W.
  localparam int LINE_CMAX = 16;

  function automatic int c_w(input int xw, input int yw);
    return (xw > yw) ? xw : yw;
  endfunction

  typedef struct packed {
    logic                 is_steep;
    logic                 v_step_neg;
    logic [LINE_CMAX-1:0] start_h;
    logic [LINE_CMAX-1:0] end_h;
    logic [LINE_CMAX-1:0] start_v;
    logic [LINE_CMAX-1:0] end_v;
    logic [LINE_CMAX-1:0] delta_h;
    logic [LINE_CMAX-1:0] delta_v;
    logic [LINE_CMAX:0]   err_init;
  } line_setup_t;
endpackage

// File: rtl/line_setup_pipe_abs.sv
// Absolute difference |a-b| of two unsigned operands of width W.
module abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = (a >= b) ? (a - b) : (b - a);
endmodule

// File: rtl/line_setup_pipe.sv
// Two-stage Bresenham setup: S1 registers endpoints, |dx|, |dy| and steepness;
// S2 swaps/orders the axes and registers the setup terms. Valid/ready with flush.
module line_setup_pipe
  import line_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int C_W = c_w(X_W, Y_W)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [C_W-1:0]      start_h,
  output logic [C_W-1:0]      end_h,
  output logic [C_W-1:0]      start_v,
  output logic [C_W-1:0]      end_v,
  output logic [C_W-1:0]      delta_h,
  output logic [C_W-1:0]      delta_v,
  output logic                v_step_neg,
  output logic signed [C_W:0] err_init,
  output logic                is_steep,
  output logic [1:0]          occupancy
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            s1_ready, s2_ready;
  logic [X_W-1:0]  dx;
  logic [Y_W-1:0]  dy;
  logic [C_W-1:0]  s1_x0, s1_x1, s1_y0, s1_y1, s1_dx, s1_dy;
  logic            s1_steep;
  logic [C_W-1:0]  h0, h1, v0, v1, sh, eh, sv, ev, dh, dv;
  logic [C_W:0]    err;
  logic            swap;
  line_setup_t     res_d, res_q;
  logic            unused_res;

  abs #(.W(X_W)) u_abs_x (.a(x0), .b(x1), .y(dx));
  abs #(.W(Y_W)) u_abs_y (.a(y0), .b(y1), .y(dy));

  assign s2_ready  = !vld_pipe[2] | out_ready;
  assign s1_ready  = !vld_pipe[1] | s2_ready;
  assign in_ready  = s1_ready & !flush;
  assign out_valid = vld_pipe[2];
  assign occupancy = {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]};

  always_comb begin
    h0   = s1_steep ? s1_y0 : s1_x0;
    h1   = s1_steep ? s1_y1 : s1_x1;
    v0   = s1_steep ? s1_x0 : s1_y0;
    v1   = s1_steep ? s1_x1 : s1_y1;
    swap = h0 > h1;
    sh   = swap ? h1 : h0;
    eh   = swap ? h0 : h1;
    sv   = swap ? v1 : v0;
    ev   = swap ? v0 : v1;
    // Ordering never changes the spans, so the S1 absolute differences are the deltas.
    dh   = s1_steep ? s1_dy : s1_dx;
    dv   = s1_steep ? s1_dx : s1_dy;
    err  = '0 - {1'b0, dh >> 1};
    res_d            = '0;
    res_d.is_steep   = s1_steep;
    res_d.v_step_neg = ev < sv;
    res_d.start_h    = LINE_CMAX'(sh);
    res_d.end_h      = LINE_CMAX'(eh);
    res_d.start_v    = LINE_CMAX'(sv);
    res_d.end_v      = LINE_CMAX'(ev);
    res_d.delta_h    = LINE_CMAX'(dh);
    res_d.delta_v    = LINE_CMAX'(dv);
    res_d.err_init   = (LINE_CMAX+1)'($signed(err));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1_x0    <= '0;
      s1_x1    <= '0;
      s1_y0    <= '0;
      s1_y1    <= '0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_steep <= 1'b0;
      res_q    <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (s1_ready) vld_pipe[1] <= in_valid;
      if (s2_ready) vld_pipe[2] <= vld_pipe[1];
      if (in_valid && s1_ready) begin
        s1_x0    <= C_W'(x0);
        s1_x1    <= C_W'(x1);
        s1_y0    <= C_W'(y0);
        s1_y1    <= C_W'(y1);
        s1_dx    <= C_W'(dx);
        s1_dy    <= C_W'(dy);
        s1_steep <= C_W'(dy) > C_W'(dx);
      end
      if (vld_pipe[1] && s2_ready) res_q <= res_d;
    end
  end

  assign is_steep   = res_q.is_steep;
  assign v_step_neg = res_q.v_step_neg;
  assign start_h    = res_q.start_h[C_W-1:0];
  assign end_h      = res_q.end_h[C_W-1:0];
  assign start_v    = res_q.start_v[C_W-1:0];
  assign end_v      = res_q.end_v[C_W-1:0];
  assign delta_h    = res_q.delta_h[C_W-1:0];
  assign delta_v    = res_q.delta_v[C_W-1:0];
  assign err_init   = res_q.err_init[C_W:0];
  assign unused_res = ^res_q;
endmodule

// File: tb/tb_line_setup_pipe.sv
// Directed and randomized checks of line_setup_pipe against a point-swap reference model.
module tb_line_setup_pipe;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int C_W = 10;

  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [X_W-1:0] x0 = '0, x1 = '0;
  logic [Y_W-1:0] y0 = '0, y1 = '0;
  logic in_ready, out_valid, v_step_neg, is_steep;
  logic [C_W-1:0] start_h, end_h, start_v, end_v, delta_h, delta_v;
  logic signed [C_W:0] err_init;
  logic [1:0] occupancy;

  line_setup_pipe #(.X_W(X_W), .Y_W(Y_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .out_valid(out_valid), .out_ready(out_ready),
    .start_h(start_h), .end_h(end_h), .start_v(start_v), .end_v(end_v),
    .delta_h(delta_h), .delta_v(delta_v), .v_step_neg(v_step_neg), .err_init(err_init),
    .is_steep(is_steep), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_out = 0;
  logic [127:0] q[$];
  wire  [127:0] obs = {55'd0, is_steep, v_step_neg, start_h, end_h, start_v, end_v,
                       delta_h, delta_v, err_init};

  function automatic logic [127:0] pk(bit st, bit vn, int sh, int eh, int sv, int ev,
                                      int dh, int dv, int err);
    return {55'd0, st, vn, C_W'(sh), C_W'(eh), C_W'(sv), C_W'(ev), C_W'(dh), C_W'(dv),
            (C_W+1)'(err)};
  endfunction

  // Reference: pick the major axis, then order the two points along it.
  function automatic logic [127:0] model(int ax0, int ay0, int ax1, int ay1);
    int dx, dy, h0, h1, v0, v1, t;
    bit st;
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    st = dy > dx;
    h0 = st ? ay0 : ax0;  h1 = st ? ay1 : ax1;
    v0 = st ? ax0 : ay0;  v1 = st ? ax1 : ay1;
    if (h0 > h1) begin
      t = h0; h0 = h1; h1 = t;
      t = v0; v0 = v1; v1 = t;
    end
    return pk(st, v1 < v0, h0, h1, v0, v1, h1 - h0, (v1 > v0) ? v1 - v0 : v0 - v1,
              -((h1 - h0) / 2));
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic set_line(input int a, input int b, input int c, input int d);
    x0 = X_W'(a); y0 = Y_W'(b); x1 = X_W'(c); y1 = Y_W'(d);
  endtask

  task automatic rnd_line();
    set_line($urandom_range(0, 1023), $urandom_range(0, 511),
             $urandom_range(0, 1023), $urandom_range(0, 511));
  endtask

  // One clock: check ready/occupancy, score any handshakes, advance to the next negedge.
  task automatic tick(output bit acc);
    #1;
    acc = 1'b0;
    chk("occupancy", occupancy, q.size());
    chk("in_ready", in_ready, !flush && (q.size() < 2 || out_ready));
    if (flush) q.delete();
    else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) chk("spurious_out", q.size(), 1);
        else chk("out", obs, q.pop_front());
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        q.push_back(model(x0, y0, x1, y1));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_chk(input string tag, input int a, input int b, input int c,
                          input int d, input logic [127:0] e);
    bit acc;
    set_line(a, b, c, d);
    in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, out_valid, 0);
    tick(acc);
    chk({tag, "_lat2"}, out_valid, 1);
    chk(tag, obs, e);
  endtask

  initial begin
    bit acc, have_snap;
    int k, n0;
    logic [127:0] snap;
    int lx0[4], ly0[4], lx1[4], ly1[4];

    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_data", obs, 0);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    out_ready = 1'b1;
    send_chk("shallow", 1, 1, 12, 5, pk(0, 0, 1, 12, 1, 5, 11, 4, -5));
    send_chk("steep",   5, 12, 1, 1, pk(1, 0, 1, 12, 1, 5, 11, 4, -5));
    send_chk("tie_neg", 1, 10, 10, 1, pk(0, 1, 1, 10, 10, 1, 9, 9, -4));
    send_chk("point",   1, 3, 1, 3, pk(0, 0, 1, 1, 3, 3, 0, 0, 0));
    tick(acc);

    // Back-to-back lines against a stalled sink.
    for (int i = 0; i < 4; i++) begin
      lx0[i] = $urandom_range(0, 1023); ly0[i] = $urandom_range(0, 511);
      lx1[i] = $urandom_range(0, 1023); ly1[i] = $urandom_range(0, 511);
    end
    out_ready = 1'b0; k = 0; have_snap = 1'b0; n0 = n_out; snap = '0;
    for (int c = 0; c < 5; c++) begin
      if (k < 4) set_line(lx0[k], ly0[k], lx1[k], ly1[k]);
      in_valid = 1'b1;
      tick(acc);
      if (acc) k++;
      if (out_valid) begin
        if (have_snap) chk("stall_hold", obs, snap);
        else begin snap = obs; have_snap = 1'b1; end
      end
    end
    #1;
    chk("stall_occ", occupancy, 2);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (k < 4 || q.size() > 0); c++) begin
      if (k < 4) begin set_line(lx0[k], ly0[k], lx1[k], ly1[k]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick(acc);
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("stall_count", n_out - n0, 4);
    chk("stall_drain", q.size(), 0);

    // Flush with both stages full and a line offered.
    out_ready = 1'b0;
    for (int c = 0; c < 4 && q.size() < 2; c++) begin
      rnd_line(); in_valid = 1'b1; tick(acc);
    end
    chk("flush_pre_occ", occupancy, 2);
    rnd_line(); in_valid = 1'b1; flush = 1'b1;
    tick(acc);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_occ", occupancy, 0);
    out_ready = 1'b1;
    tick(acc); tick(acc); tick(acc);

    // Asynchronous reset mid-stream.
    rnd_line(); in_valid = 1'b1; tick(acc);
    rnd_line(); tick(acc);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_occ", occupancy, 0);
    chk("areset_data", obs, 0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    send_chk("post_reset", 300, 20, 7, 400, model(300, 20, 7, 400));
    tick(acc);

    // Randomized traffic with backpressure and occasional flush.
    for (int c = 0; c < 400; c++) begin
      rnd_line();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick(acc);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) tick(acc);
    chk("final_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
